// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: asynchronous serial receiver feeding a first-word
// fall-through receive FIFO.
//
// The receiver oversamples a 2-flop-synchronised rx line at CLKS_PER_BIT
// clocks per bit and samples each bit at its middle. Each completed frame is
// pushed as {framing-error, parity-error, data}. A frame that is all zeros
// up to and including the first stop bit is treated as a line break: it sets
// a sticky flag and nothing is pushed.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial line, idles high
//   received  in   pop strobe; honoured only while sent=1
//   clr_err   in   clears sticky error[3:2] (a same-cycle set wins)
//   data      out  head entry data, 0 when the FIFO is empty
//   sent      out  FIFO non-empty
//   error     out  [0] head parity, [1] head framing, [2] overrun (sticky),
//                  [3] break (sticky); [1:0] are 0 when the FIFO is empty
//   count     out  FIFO occupancy 0..FIFO_DEPTH
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          received,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          data,
  output logic                          sent,
  output logic [3:0]                    error,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CCNT_W = PTR_W + 1;
  localparam int ENT_W  = DATA_BITS + 2;

  localparam logic [CNT_W-1:0]  HALF_C      = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_C      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_DATA_C = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_STOP_C = IDX_W'(STOP_BITS - 1);
  localparam logic [CCNT_W-1:0] DEPTH_C     = CCNT_W'(FIFO_DEPTH);
  localparam logic              HAS_PAR_C   = (PARITY != 0);
  localparam logic              ODD_C       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Parity bit the transmitter should have sent for a given data word.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ODD_C;
  endfunction

  // Synchroniser and start-detect arming
  logic       sync1_q, sync2_q;
  logic       rx_s;
  logic [1:0] fill_q;
  logic       armed_q;

  // Receiver FSM and datapath
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic                 fe_q, fe_d;

  logic tick_half, tick_full, stop_smp;
  logic frame_pe, frame_fe;
  logic brk_evt, push_evt;

  // FIFO
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CCNT_W-1:0] count_q, count_d;
  logic              full_w, pop_w, wr_w, ovr_evt;
  logic              ovr_q, brk_q;
  logic [ENT_W-1:0]  head_w;

  assign rx_s = sync2_q;

  // ---- Stage: input synchroniser ----
  // fill_q tracks when the synchroniser again carries the real line value
  // after reset. Start detection is armed only once that real value has been
  // seen high, so a line that is still low from an abandoned frame is not
  // mistaken for a new start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  // ---- Stage: receiver state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    pbit_q  <= pbit_d;
    fe_q    <= fe_d;
  end

  // ---- Stage: receiver events (FSM outputs) ----
  // A break is decided on the first stop sample: the data bits, the parity
  // bit and this stop bit are all zero.
  always_comb begin
    tick_half = (cnt_q == HALF_C);
    tick_full = (cnt_q == FULL_C);
    stop_smp  = (state_q == S_STOP) && tick_full;
    frame_pe  = HAS_PAR_C && (pbit_q != expected_parity(shift_q));
    frame_fe  = fe_q | ~rx_s;
    brk_evt   = stop_smp && (idx_q == '0) && (shift_q == '0) &&
                (!HAS_PAR_C || !pbit_q) && !rx_s;
    push_evt  = stop_smp && (idx_q == LAST_STOP_C) && !brk_evt;
  end

  // ---- Stage: receiver next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (tick_half) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick_full && (idx_q == LAST_DATA_C)) begin
          state_d = HAS_PAR_C ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick_full) state_d = S_STOP;
      end
      S_STOP: begin
        if (brk_evt) begin
          state_d = S_WAIT_HIGH;
        end else if (stop_smp && (idx_q == LAST_STOP_C)) begin
          state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- Stage: receiver datapath ----
  // The bit counter restarts at every sample so the following sample lands
  // exactly one bit period later, in the middle of the next bit.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pbit_d  = pbit_q;
    fe_d    = fe_q;
    case (state_q)
      S_IDLE, S_WAIT_HIGH: begin
        cnt_d = '0;
        idx_d = '0;
      end
      S_START: begin
        if (tick_half) begin
          cnt_d = '0;
          fe_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = (idx_q == LAST_DATA_C) ? '0 : idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick_full) begin
          cnt_d  = '0;
          pbit_d = rx_s;
        end
      end
      S_STOP: begin
        if (tick_full) begin
          cnt_d = '0;
          fe_d  = frame_fe;
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  // ---- Stage: FIFO control ----
  // A pop in the same clock frees the slot the push needs, so a full FIFO
  // only overruns when nobody pops. A pop while empty is ignored.
  always_comb begin
    full_w  = (count_q == DEPTH_C);
    pop_w   = received && (count_q != '0);
    wr_w    = push_evt && (!full_w || pop_w);
    ovr_evt = push_evt && full_w && !pop_w;
    count_d = count_q;
    case ({wr_w, pop_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      if (wr_w)  wptr_q <= wptr_q + 1'b1;
      if (pop_w) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ovr_q   <= ovr_evt ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
      brk_q   <= brk_evt ? 1'b1 : (clr_err ? 1'b0 : brk_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_w) begin
      mem_q[wptr_q] <= {frame_fe, frame_pe, shift_q};
    end
  end

  // ---- Stage: fall-through outputs ----
  always_comb begin
    head_w = mem_q[rptr_q];
    sent   = (count_q != '0);
    data   = sent ? head_w[DATA_BITS-1:0] : '0;
    error  = {brk_q, ovr_q, sent ? head_w[ENT_W-1:DATA_BITS] : 2'b00};
    count  = count_q;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Parameters
REQ-001 DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 PARITY, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-003 STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 CLKS_PER_BIT, default 16, clk cycles per bit; must be even and >=4.
REQ-005 FIFO_DEPTH, default 4, receive FIFO entries; must be a power of 2 and >=2.

Interface
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 rx  in  1  asynchronous serial line; idles high.
REQ-009 received  in  1  consumer pop strobe; acts only when sent=1.
REQ-010 clr_err  in  1  clears the sticky error bits error[3:2].
REQ-011 data  out  DATA_BITS  data of the FIFO head entry; 0 when FIFO empty.
REQ-012 sent  out  1  FIFO non-empty (head valid).
REQ-013 error  out  4  [0] head parity error, [1] head framing error, [2] overrun (sticky), [3] break (sticky); [1:0] are 0 when FIFO empty.
REQ-014 count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-015 rx passes through a 2-flop synchroniser; both flops reset to 1; every reference to rx below means the synchronised value.
REQ-016 Receiver FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; a bit counter (0..CLKS_PER_BIT-1) and a bit index drive sampling.
REQ-017 IDLE: rx=0 -> START with bit counter cleared; otherwise stay in IDLE.
REQ-018 START: sample when bit counter reaches CLKS_PER_BIT/2-1; rx=1 -> IDLE (glitch rejected, nothing pushed); rx=0 -> DATA with bit counter cleared.
REQ-019 DATA: sample every CLKS_PER_BIT clocks (mid-bit), LSB first, into the shift register; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-020 PARITY: sample one bit; expected bit = XOR of data bits for even parity and its inverse for odd; mismatch sets the frame's parity-error flag.
REQ-021 STOP: sample STOP_BITS bits; any 0 sets the frame's framing-error flag.
REQ-022 Break: all data bits 0, the parity bit (if present) 0, and the first stop bit 0 -> set error[3]; push nothing; go to WAIT_HIGH immediately.
REQ-023 Frame end, non-break: on the clock of the final stop-bit sample, push {framing-error, parity-error, data}; go to IDLE if that sample is 1, else to WAIT_HIGH.
REQ-024 WAIT_HIGH: stay until rx=1, then go to IDLE; no start bit is detected in this state.
REQ-025 Push latency: sent, data and error[1:0] reflect a pushed frame one clk after the final stop-bit sample when the FIFO was previously empty.
REQ-026 FIFO is first-word fall-through; data and error[1:0] are driven combinationally from the head entry.
REQ-027 Pop: the head entry is removed at the clock edge where sent=1 and received=1; received while sent=0 is ignored.
REQ-028 Full: a push while count=FIFO_DEPTH with no pop in the same clock drops the new frame, keeps the FIFO contents, and sets error[2].
REQ-029 Simultaneous push and pop while full: both are accepted, no overrun, count stays at FIFO_DEPTH.
REQ-030 Simultaneous push and pop while empty: the push is accepted, the pop is ignored, count becomes 1.
REQ-031 Pointers wrap modulo FIFO_DEPTH; count is tracked separately so full and empty are unambiguous.
REQ-032 clr_err=1 clears error[3:2] at the next edge; if a set event occurs in the same clock, the set wins.

Reset
REQ-033 rst=1 at an edge forces: FSM to IDLE, bit counter and index to 0, FIFO empty, count=0, sent=0, data=0, error=0, synchroniser flops to 1.
REQ-034 Reset mid-frame abandons the partial frame; nothing is pushed; the next start bit is detected only after rst is released and rx has been seen high and then low.

Verification (DATA_BITS=8, PARITY=1, STOP_BITS=1, CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-035 Frame 0xA5 with parity bit 0 and stop bit 1 -> sent=1 one clk after the stop-bit sample, data=0xA5, error=0, count=1; one-clk received pulse -> sent=0, count=0.
REQ-036 Frame 0xA5 with parity bit 1 -> entry pushed with data=0xA5, error[0]=1; frame 0x3C with stop bit 0 -> error[1]=1, FSM in WAIT_HIGH until rx returns high.
REQ-037 Five valid frames 0x01..0x05, no pops -> count=4, error[2]=1; pops return 0x01..0x04 in order; clr_err pulse -> error[2]=0.
REQ-038 rx low for 6 clks, then high -> no push, FSM back in IDLE, sent stays 0.
REQ-039 rx held low for 12 bit times -> error[3]=1, count unchanged; the next valid frame after rx goes high is received correctly.
REQ-040 rst asserted during data bit 4 of a frame -> all outputs at reset values; a following clean 0x5A frame is received with error=0.
